hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. Decides each cycle whether the front end advances, stalls or flushes: it detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and holds the pipeline around a multi-cycle multiply/divide unit with a timeout. Its outputs drive the PC enable, the IF/ID register, and the `flush`/hold inputs of the ID/EX register. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bundle between the RISC-V datapath and hazard_ctrl.
// master = datapath side (drives hazard sources), slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic [4:0]       rd_ex;
  logic             Memread_ex;
  logic             branch_taken_ex;
  logic             jump_ex;
  logic             md_start_ex;
  logic             md_done;
  logic             cnt_clr;
  logic             stall_pc;
  logic             stall_if_id;
  logic             hold_id_ex;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             md_busy;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, Memread_ex,
           branch_taken_ex, jump_ex, md_start_ex, md_done, cnt_clr,
    input  stall_pc, stall_if_id, hold_id_ex, flush_if_id, flush_id_ex,
           md_busy, md_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, Memread_ex,
           branch_taken_ex, jump_ex, md_start_ex, md_done, cnt_clr,
    output stall_pc, stall_if_id, hold_id_ex, flush_if_id, flush_id_ex,
           md_busy, md_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes, mul/div
// hold with timeout, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rstn,
  hazard_ctrl_if.slave bus
);

  localparam int TCNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MD_TIMEOUT - 1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [TCNT_W-1:0] tcnt_reg, tcnt_next;

  logic lu;
  logic redir;
  logic rs1_hit;
  logic rs2_hit;

  logic stall_pc_c;
  logic stall_if_id_c;
  logic hold_id_ex_c;
  logic flush_if_id_c;
  logic flush_id_ex_c;
  logic md_busy_c;
  logic md_timeout_c;

  logic [1:0][CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]            cnt_evt;

  assign rs1_hit = bus.rs1_used_id && (bus.rs1_id == bus.rd_ex);
  assign rs2_hit = bus.rs2_used_id && (bus.rs2_id == bus.rd_ex);
  assign lu      = bus.Memread_ex && (bus.rd_ex != 5'd0) && (rs1_hit || rs2_hit);
  assign redir   = bus.branch_taken_ex || bus.jump_ex;

  always_comb begin
    state_next    = state_reg;
    tcnt_next     = tcnt_reg;
    stall_pc_c    = 1'b0;
    stall_if_id_c = 1'b0;
    hold_id_ex_c  = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    md_busy_c     = 1'b0;
    md_timeout_c  = 1'b0;

    case (state_reg)
      RUN: begin
        if (redir) begin
          // A redirect squashes whatever the hazards would have protected.
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end else if (bus.md_start_ex && !bus.md_done) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          hold_id_ex_c  = 1'b1;
          state_next    = MD_WAIT;
          tcnt_next     = '0;
        end else if (bus.md_start_ex && bus.md_done) begin
          // Single-cycle result: the pipeline just flows.
        end else if (lu) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end
      end

      MD_WAIT: begin
        md_busy_c = 1'b1;
        if (bus.md_done) begin
          state_next = RUN;
          tcnt_next  = '0;
        end else if (tcnt_reg == TCNT_LAST) begin
          md_timeout_c = 1'b1;
          state_next   = RUN;
          tcnt_next    = '0;
        end else begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          hold_id_ex_c  = 1'b1;
          tcnt_next     = tcnt_reg + TCNT_W'(1);
        end
      end

      default: begin
        state_next = RUN;
        tcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= RUN;
      tcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  // Index 0 counts stalled PC cycles, index 1 counts redirects.
  assign cnt_evt = {flush_if_id_c, stall_pc_c};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      assign cnt_next[gi] = bus.cnt_clr                          ? '0 :
                            (cnt_evt[gi] && (cnt_reg[gi] != '1)) ? cnt_reg[gi] + CNT_W'(1) :
                                                                   cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just at the edge.
  assign bus.stall_pc     = rstn && stall_pc_c;
  assign bus.stall_if_id  = rstn && stall_if_id_c;
  assign bus.hold_id_ex   = rstn && hold_id_ex_c;
  assign bus.flush_if_id  = rstn && flush_if_id_c;
  assign bus.flush_id_ex  = rstn && flush_id_ex_c;
  assign bus.md_busy      = rstn && md_busy_c;
  assign bus.md_timeout   = rstn && md_timeout_c;
  assign bus.stall_cycles = cnt_reg[0];
  assign bus.flush_events = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: whether a mul/div wait is in progress, how many wait
  // cycles have elapsed, and the two event tallies as plain integers.
  bit m_busy    = 1'b0;
  int m_elapsed = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rs1_id          = 5'd0;
    bus.rs2_id          = 5'd0;
    bus.rs1_used_id     = 1'b0;
    bus.rs2_used_id     = 1'b0;
    bus.rd_ex           = 5'd0;
    bus.Memread_ex      = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.jump_ex         = 1'b0;
    bus.md_start_ex     = 1'b0;
    bus.md_done         = 1'b0;
    bus.cnt_clr         = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs2, input logic used);
    bus.Memread_ex  = 1'b1;
    bus.rd_ex       = rd;
    bus.rs2_id      = rs2;
    bus.rs2_used_id = used;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model at the edge,
  // then check the counters just after it.
  task automatic cycle(input string tag);
    bit lu, redir, leave;
    logic [6:0] e;
    logic [6:0] o;
    @(negedge clk);
    lu = bus.Memread_ex && (bus.rd_ex != 0) &&
         ((bus.rs1_used_id && bus.rs1_id == bus.rd_ex) ||
          (bus.rs2_used_id && bus.rs2_id == bus.rd_ex));
    redir = bus.branch_taken_ex || bus.jump_ex;
    e     = 7'b0;
    leave = 1'b0;
    // e = {stall_pc, stall_if_id, hold_id_ex, flush_if_id, flush_id_ex, md_busy, md_timeout}
    if (!rstn) begin
      m_busy = 1'b0; m_elapsed = 0; m_stall = 0; m_flush = 0;
    end else if (m_busy) begin
      e[1] = 1'b1;
      if (bus.md_done) leave = 1'b1;
      else if (m_elapsed == MD_TIMEOUT - 1) begin e[0] = 1'b1; leave = 1'b1; end
      else e[6:4] = 3'b111;
    end else if (redir) begin
      e[3:2] = 2'b11;
    end else if (bus.md_start_ex && !bus.md_done) begin
      e[6:4] = 3'b111;
    end else if (bus.md_start_ex && bus.md_done) begin
      e = 7'b0;
    end else if (lu) begin
      e[6] = 1'b1; e[5] = 1'b1; e[2] = 1'b1;
    end
    o = {bus.stall_pc, bus.stall_if_id, bus.hold_id_ex, bus.flush_if_id,
         bus.flush_id_ex, bus.md_busy, bus.md_timeout};
    chk({tag, ".ctrl"}, 32'(o), 32'(e));
    chk({tag, ".hold_vs_bubble"}, 32'(bus.hold_id_ex && bus.flush_id_ex), 32'd0);
    @(posedge clk);
    if (rstn) begin
      if (bus.cnt_clr) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (e[6] && m_stall < CNT_MAX) m_stall++;
        if (e[3] && m_flush < CNT_MAX) m_flush++;
      end
      if (m_busy) begin
        if (leave) m_busy = 1'b0;
        else m_elapsed++;
      end else if (!redir && bus.md_start_ex && !bus.md_done) begin
        m_busy = 1'b1; m_elapsed = 0;
      end
    end
    #1;
    chk({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(m_stall));
    chk({tag, ".flush_events"}, 32'(bus.flush_events), 32'(m_flush));
    $display("%-14s ctrl=%b stall_cycles=%0d flush_events=%0d", tag, o, bus.stall_cycles, bus.flush_events);
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    cycle("reset");
    cycle("reset");
    rstn = 1'b1;
    cycle("idle");

    // Load-use on rs2, then the two non-hazard variants.
    set_lu(5'd5, 5'd5, 1'b1);
    cycle("lu");
    clear_inputs();
    cycle("lu_after");
    set_lu(5'd0, 5'd0, 1'b1);
    cycle("lu_rd0");
    set_lu(5'd5, 5'd5, 1'b0);
    cycle("lu_unused");
    clear_inputs();

    // Redirect beats a simultaneous load-use.
    set_lu(5'd7, 5'd7, 1'b1);
    bus.branch_taken_ex = 1'b1;
    cycle("redir_lu");
    clear_inputs();
    bus.jump_ex = 1'b1;
    cycle("jump");
    clear_inputs();
    chk("flush_events_2", 32'(bus.flush_events), 32'd2);

    // Mul/div: done arrives 4 cycles after start, counters cleared first.
    bus.cnt_clr = 1'b1;
    cycle("clr");
    clear_inputs();
    bus.md_start_ex = 1'b1;
    cycle("md_start");
    bus.md_start_ex = 1'b0;
    for (int i = 1; i < 4; i++) cycle($sformatf("md_wait%0d", i));
    bus.md_done = 1'b1;
    cycle("md_done");
    bus.md_done = 1'b0;
    chk("md_stall_4", 32'(bus.stall_cycles), 32'd4);

    // Single-cycle mul/div result.
    bus.md_start_ex = 1'b1;
    bus.md_done     = 1'b1;
    cycle("md_fast");
    clear_inputs();

    // Timeout: no done at all, then a load-use right afterwards.
    bus.cnt_clr = 1'b1;
    cycle("clr");
    clear_inputs();
    bus.md_start_ex = 1'b1;
    cycle("to_start");
    bus.md_start_ex = 1'b0;
    for (int i = 1; i <= MD_TIMEOUT; i++) cycle($sformatf("to_wait%0d", i));
    chk("to_stall_total", 32'(bus.stall_cycles), 32'(MD_TIMEOUT));
    set_lu(5'd9, 5'd9, 1'b1);
    cycle("lu_after_to");
    clear_inputs();

    // Reset dropped during the third wait cycle.
    bus.md_start_ex = 1'b1;
    cycle("rst_start");
    bus.md_start_ex = 1'b0;
    cycle("rst_wait1");
    cycle("rst_wait2");
    rstn = 1'b0;
    cycle("rst_wait3");
    cycle("rst_hold");
    rstn = 1'b1;
    cycle("rst_release");
    cycle("rst_idle");

    // Saturation with 20 consecutive load-use stalls, then clear mid-stall.
    set_lu(5'd3, 5'd3, 1'b1);
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i));
    chk("sat_15", 32'(bus.stall_cycles), 32'd15);
    bus.cnt_clr = 1'b1;
    cycle("clr_in_stall");
    chk("clr_zero", 32'(bus.stall_cycles), 32'd0);
    clear_inputs();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.rs1_id          = 5'($urandom_range(0, 3));
      bus.rs2_id          = 5'($urandom_range(0, 3));
      bus.rd_ex           = 5'($urandom_range(0, 3));
      bus.rs1_used_id     = 1'($urandom_range(0, 1));
      bus.rs2_used_id     = 1'($urandom_range(0, 1));
      bus.Memread_ex      = ($urandom_range(0, 2) == 0);
      bus.branch_taken_ex = ($urandom_range(0, 7) == 0);
      bus.jump_ex         = ($urandom_range(0, 11) == 0);
      bus.md_start_ex     = ($urandom_range(0, 5) == 0);
      bus.md_done         = ($urandom_range(0, 4) == 0);
      bus.cnt_clr         = ($urandom_range(0, 39) == 0);
      cycle($sformatf("rand%0d", i));
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
